// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin synchronisers, glitch filters, 11-bit frame
// decoder with start/parity/stop/timeout checks, and a byte FIFO drained by valid/ready.
module ps2_rx_fifo #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_US  = 200
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          PS2_CLK,
  input  logic                          PS2_DATA,
  output logic [7:0]                    o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_parity_err,
  output logic                          o_frame_err,
  output logic                          o_overflow,
  input  logic                          i_clr
);

  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned FW        = $clog2(FILTER_LEN + 1);
  localparam int unsigned TO_CYCLES = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
  localparam int unsigned TW        = $clog2(TO_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync, dat_sync;
  logic [1:0]    line_sync, line_filt;
  logic [FW-1:0] filt_cnt [2];
  logic          filt_clk_d;
  logic          fall, din;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[0], PS2_CLK};
      dat_sync <= {dat_sync[0], PS2_DATA};
    end
  end

  assign line_sync = {dat_sync[1], clk_sync[1]};

  // Bit 0 is the clock line, bit 1 the data line.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      line_filt  <= '1;
      filt_clk_d <= 1'b1;
      for (int unsigned i = 0; i < 2; i++) filt_cnt[i] <= '0;
    end else begin
      filt_clk_d <= line_filt[0];
      for (int unsigned i = 0; i < 2; i++) begin
        if (line_sync[i] != line_filt[i]) begin
          if (filt_cnt[i] == FW'(FILTER_LEN - 1)) begin
            line_filt[i] <= line_sync[i];
            filt_cnt[i]  <= '0;
          end else begin
            filt_cnt[i] <= filt_cnt[i] + FW'(1);
          end
        end else begin
          filt_cnt[i] <= '0;
        end
      end
    end
  end

  assign fall = filt_clk_d & ~line_filt[0];
  assign din  = line_filt[1];

  state_t        state_q, state_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [2:0]    bitidx_q, bitidx_d;
  logic          par_q, par_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          push, perr, ferr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bitidx_q     <= '0;
      par_q        <= 1'b0;
      tcnt_q       <= '0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bitidx_q     <= bitidx_d;
      par_q        <= par_d;
      tcnt_q       <= tcnt_d;
      o_parity_err <= perr;
      o_frame_err  <= ferr;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitidx_d = bitidx_q;
    par_d    = par_q;
    tcnt_d   = tcnt_q;
    push     = 1'b0;
    perr     = 1'b0;
    ferr     = 1'b0;
    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        if (fall) begin
          if (!din) begin
            state_d  = DATA;
            bitidx_d = '0;
          end else begin
            ferr = 1'b1;
          end
        end
      end
      DATA: begin
        if (fall) begin
          shreg_d  = {din, shreg_q[7:1]};
          bitidx_d = bitidx_q + 3'd1;
          if (bitidx_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          par_d   = din;
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          if (!din)                  ferr = 1'b1;
          else if (!(^shreg_q ^ par_q)) perr = 1'b1;
          else                       push = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Timeout only runs while a frame is open; every fall restarts it.
    if (state_q != IDLE) begin
      if (fall) begin
        tcnt_d = '0;
      end else if (tcnt_q == TW'(TO_CYCLES - 1)) begin
        ferr    = 1'b1;
        state_d = IDLE;
        tcnt_d  = '0;
      end else begin
        tcnt_d = tcnt_q + TW'(1);
      end
    end
  end

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, rd_next;
  logic        full, pop, push_ok, drop;

  assign o_count = wr_ptr - rd_ptr;
  assign o_valid = (wr_ptr != rd_ptr);
  assign full    = (o_count == (AW+1)'(FIFO_DEPTH));
  assign pop     = o_valid & i_ready;
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;
  assign rd_next = rd_ptr + (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= shreg_q;
  end

  // o_data is registered: load the incoming byte when it lands at the head,
  // otherwise the stored entry that becomes the head.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_data     <= '0;
      o_overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(push_ok);
      rd_ptr <= rd_next;
      if (push_ok && (rd_next == wr_ptr)) o_data <= shreg_q;
      else if (rd_next != wr_ptr)         o_data <= mem[rd_next[AW-1:0]];
      if (drop)       o_overflow <= 1'b1;
      else if (i_clr) o_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: vector table of frames, hand-written
// corner sequences, and randomized frames checked against a queue model.
module tb_ps2_rx_fifo;
  localparam int unsigned CLKF  = 1_000_000;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned FLEN  = 8;
  localparam int unsigned TOUS  = 200;
  localparam int TO   = CLKF / 1_000_000 * TOUS;
  localparam int LAT  = 2 + FLEN + 1;
  localparam int HALF = 20;
  localparam int GAP  = 30;

  logic       clk, rstn, ps2_clk, ps2_data, i_ready, i_clr;
  logic [7:0] o_data;
  logic       o_valid, o_parity_err, o_frame_err, o_overflow;
  logic [4:0] o_count;

  ps2_rx_fifo #(.CLK_FREQ_HZ(CLKF), .FIFO_DEPTH(DEPTH), .FILTER_LEN(FLEN), .TIMEOUT_US(TOUS)) dut (
    .clk(clk), .rstn(rstn), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_count(o_count),
    .o_parity_err(o_parity_err), .o_frame_err(o_frame_err), .o_overflow(o_overflow),
    .i_clr(i_clr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: byte queue, pending push due LAT cycles after the stop fall.
  logic [7:0] q[$];
  bit         pend_valid = 0;
  logic [7:0] pend_byte;
  int         pend_cyc;
  bit         exp_ovf = 0;
  int         exp_perr = 0, exp_ferr = 0;
  int         perr_cnt = 0, ferr_cnt = 0, pops = 0;
  logic [7:0] last_pop = '0;
  bit         mon_en = 0, perr_prev = 0, ferr_prev = 0;
  int         last_fall;

  always @(negedge clk) begin
    if (mon_en) begin
      if (o_parity_err) begin perr_cnt++; check("perr_1cycle", int'(perr_prev), 0); end
      if (o_frame_err)  begin ferr_cnt++; check("ferr_1cycle", int'(ferr_prev), 0); end
      perr_prev = o_parity_err;
      ferr_prev = o_frame_err;
      if (o_valid && i_ready) begin
        if (q.size() == 0) check("pop_underflow", 1, 0);
        else begin
          logic [7:0] e;
          e = q.pop_front();
          check("pop_data", int'(o_data), int'(e));
          last_pop = o_data;
          pops++;
        end
      end
      if (pend_valid && (cyc + 1 == pend_cyc)) begin
        pend_valid = 0;
        if (q.size() < DEPTH) q.push_back(pend_byte);
        else exp_ovf = 1;
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input bit glitch);
    logic [10:0] bits;
    logic p;
    p = ~(^b) ^ bad_par;
    bits = {~bad_stop, p, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1 ps2_data = bits[i];
      for (int c = 0; c < HALF; c++) begin
        @(posedge clk); #1;
        if (glitch && c == 5) ps2_clk = 1'b0;
        if (glitch && c == 8) ps2_clk = 1'b1;
      end
      ps2_clk = 1'b0;
      last_fall = cyc;
      if (i == 10) begin
        if (bad_stop)     exp_ferr++;
        else if (bad_par) exp_perr++;
        else begin
          pend_byte = b; pend_cyc = cyc + LAT; pend_valid = 1;
        end
      end
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b1;
    end
    repeat (GAP) @(posedge clk);
    #1;
  endtask

  task automatic check_errs();
    check("perr_count", perr_cnt, exp_perr);
    check("ferr_count", ferr_cnt, exp_ferr);
  endtask

  task automatic check_quiet(input string tag);
    @(negedge clk);
    check({tag, "_count"}, int'(o_count), q.size());
    check({tag, "_valid"}, int'(o_valid), int'(q.size() != 0));
    check({tag, "_ovf"}, int'(o_overflow), int'(exp_ovf));
  endtask

  task automatic drain();
    bit done = 0;
    @(posedge clk); #1 i_ready = 1'b1;
    for (int k = 0; k < 4 * DEPTH + 10; k++) begin
      @(posedge clk); #2;
      if (!o_valid) begin done = 1; break; end
    end
    if (!done) check("drain_timeout", 1, 0);
    repeat (3) @(posedge clk);
    #1 i_ready = 1'b0;
    check("drain_model_empty", q.size(), 0);
    @(negedge clk);
    check("drain_valid", int'(o_valid), 0);
    check("drain_count", int'(o_count), 0);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         bad_par;
    bit         bad_stop;
    int         exp_count;
    logic [7:0] exp_head;
    int         exp_perr_inc;
    int         exp_ferr_inc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #(20_000_000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, f0, pops0;
    bit seen;
    vecs[0] = '{8'h1C, 0, 0, 1, 8'h1C, 0, 0};
    vecs[1] = '{8'hF0, 1, 0, 1, 8'h1C, 1, 0};
    vecs[2] = '{8'hF0, 0, 0, 2, 8'h1C, 0, 0};
    vecs[3] = '{8'h00, 0, 1, 2, 8'h1C, 0, 1};
    vecs[4] = '{8'hFF, 0, 0, 3, 8'h1C, 0, 0};
    vecs[5] = '{8'h81, 1, 0, 3, 8'h1C, 1, 0};
    vecs[6] = '{8'h5A, 0, 0, 4, 8'h1C, 0, 0};
    vecs[7] = '{8'h7E, 1, 1, 4, 8'h1C, 0, 1};

    rstn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; i_ready = 1'b0; i_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data", int'(o_data), 0);
    check("rst_valid", int'(o_valid), 0);
    check("rst_count", int'(o_count), 0);
    check("rst_perr", int'(o_parity_err), 0);
    check("rst_ferr", int'(o_frame_err), 0);
    check("rst_ovf", int'(o_overflow), 0);
    @(posedge clk); #1 rstn = 1'b1; mon_en = 1;
    repeat (20) @(posedge clk);
    #1;

    // Table-driven frames with the consumer stalled.
    for (int i = 0; i < 8; i++) begin
      p0 = perr_cnt; f0 = ferr_cnt;
      send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop, 11, 0);
      @(negedge clk);
      check($sformatf("vec%0d_count", i), int'(o_count), vecs[i].exp_count);
      check($sformatf("vec%0d_head", i), int'(o_data), int'(vecs[i].exp_head));
      check($sformatf("vec%0d_perr", i), perr_cnt - p0, vecs[i].exp_perr_inc);
      check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr_inc);
      check_errs();
    end
    drain();
    check("table_last_out", int'(last_pop), 8'h5A);

    // Glitched clock line.
    send_frame(8'h5A, 0, 0, 11, 1);
    check_quiet("glitch");
    check("glitch_head", int'(o_data), 8'h5A);
    check_errs();
    drain();

    // Bad start bit: single fall with data high.
    @(posedge clk); #1 ps2_data = 1'b1;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b0; exp_ferr++;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (GAP) @(posedge clk);
    check_errs();
    check_quiet("badstart");

    // Timeout after start + 4 data bits, then a clean frame.
    send_frame(8'hA5, 0, 0, 5, 0);
    exp_ferr++;
    seen = 0;
    for (int k = 0; k < 2 * TO; k++) begin
      @(negedge clk);
      if (o_frame_err) begin seen = 1; break; end
    end
    check("timeout_seen", int'(seen), 1);
    if (seen) check("timeout_latency", cyc - last_fall, LAT + TO);
    repeat (GAP) @(posedge clk);
    #1;
    check_errs();
    send_frame(8'h29, 0, 0, 11, 0);
    check_quiet("after_to");
    check("after_to_head", int'(o_data), 8'h29);
    check_errs();
    drain();

    // Overflow: 17 bytes into a 16-deep FIFO.
    for (int b = 1; b <= 17; b++) send_frame(8'(b), 0, 0, 11, 0);
    check_quiet("ovf");
    check("ovf_count16", int'(o_count), 16);
    check("ovf_set", int'(o_overflow), 1);
    pops0 = pops;
    drain();
    check("ovf_pops", pops - pops0, 16);
    check("ovf_last_out", int'(last_pop), 8'h10);
    @(posedge clk); #1 i_clr = 1'b1;
    @(posedge clk); #1 i_clr = 1'b0; exp_ovf = 0;
    @(negedge clk);
    check("ovf_clr", int'(o_overflow), 0);

    // Full FIFO, push and pop on the same edge.
    for (int b = 0; b < 16; b++) send_frame(8'h30 + 8'(b), 0, 0, 11, 0);
    check_quiet("full");
    fork
      send_frame(8'h22, 0, 0, 11, 0);
      begin
        int due;
        wait (pend_valid);
        due = pend_cyc;
        while (cyc < due - 1) begin @(posedge clk); #1; end
        i_ready = 1'b1;
        @(posedge clk); #1 i_ready = 1'b0;
      end
    join
    check_quiet("full_pp");
    check("full_pp_count", int'(o_count), 16);
    check("full_pp_ovf", int'(o_overflow), 0);
    check("full_pp_head", int'(o_data), 8'h31);
    drain();
    check("full_pp_last", int'(last_pop), 8'h22);
    check_errs();

    // Randomized frames with a randomly stalling consumer.
    for (int n = 0; n < 20; n++) begin
      logic [7:0] rb;
      bit bp, bs;
      rb = 8'($urandom);
      bp = ($urandom_range(0, 5) == 0);
      bs = ($urandom_range(0, 7) == 0);
      fork
        send_frame(rb, bp, bs, 11, 0);
        repeat (400) begin @(posedge clk); #1 i_ready = 1'($urandom_range(0, 1)); end
      join
      check_errs();
    end
    drain();
    check_quiet("rand_end");

    // Reset mid-frame with bytes buffered.
    for (int b = 0; b < 3; b++) send_frame(8'hC0 + 8'(b), 0, 0, 11, 0);
    check_quiet("pre_rst");
    send_frame(8'hAA, 0, 0, 4, 0);
    @(posedge clk); #1 rstn = 1'b0;
    @(negedge clk);
    check("mid_rst_data", int'(o_data), 0);
    check("mid_rst_valid", int'(o_valid), 0);
    check("mid_rst_count", int'(o_count), 0);
    check("mid_rst_perr", int'(o_parity_err), 0);
    check("mid_rst_ferr", int'(o_frame_err), 0);
    check("mid_rst_ovf", int'(o_overflow), 0);
    q.delete(); pend_valid = 0; exp_ovf = 0;
    @(posedge clk); #1 rstn = 1'b1;
    repeat (GAP) @(posedge clk);
    #1;
    send_frame(8'h77, 0, 0, 11, 0);
    check_quiet("post_rst");
    check("post_rst_head", int'(o_data), 8'h77);
    drain();
    check_errs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
